// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_D  = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [1:0] STRB_BYTE  = 2'b00;
    localparam logic [1:0] STRB_HALF  = 2'b01;
    localparam logic [1:0] STRB_WORD  = 2'b10;

    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_IF     = 2'd1;
    localparam logic [1:0] OWN_D      = 2'd2;

    // The busy state already identifies which requester holds the memory.
    function automatic logic [1:0] owner_of(input logic [1:0] st);
        case (st)
            ST_BUSY_IF: owner_of = OWN_IF;
            ST_BUSY_D:  owner_of = OWN_D;
            default:    owner_of = OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts data grants won while a fetch waits; flags when the fetch must be served.
// Latency: flag is registered, reflects grants up to the previous edge. No backpressure.
module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    logic [3:0] r_cnt;

    assign o_at_max = (r_cnt >= 4'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && !o_at_max) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and load/store, data first with bounded fetch wait.
// Latency: grant edge -> mem_req next cycle; done one cycle after mem_ready (min 3 cycles).
// Backpressure: requesters hold req until done; stall_* freeze the pipeline. Optional MEM_ARB_TIMEOUT_EN watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_strobe,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_d,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_strobe,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic              err_timeout
`endif
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("mem_port_arbiter: STARVE_MAX must be 1..15 and TIMEOUT_CYC >= 1");
    end

    logic [1:0]        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_mem_strobe;
    logic              r_if_done;
    logic              r_d_done;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_idle;
    logic              w_busy;
    logic              w_starved;
    logic              w_grant_d;
    logic              w_grant_if;
    logic              w_timeout;
    logic              w_complete;
    logic [DATA_W-1:0] w_rsp_data;
    logic [1:0]        w_owner;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_busy     = (r_state == ST_BUSY_IF) || (r_state == ST_BUSY_D);
    assign w_grant_d  = w_idle && d_req && (!if_req || !w_starved);
    assign w_grant_if = w_idle && if_req && !w_grant_d;
    assign w_complete = w_busy && (mem_ready || w_timeout);
    assign w_rsp_data = mem_ready ? mem_rdata : '0;
    assign w_owner    = owner_of(r_state);

    // Any idle cycle without a data grant (fetch served or nothing pending) resets the fairness count.
    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_grant_d && if_req),
        .i_clr    (w_idle && !w_grant_d),
        .o_at_max (w_starved)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err_timeout;

    assign w_timeout   = w_busy && !mem_ready && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign err_timeout = r_err_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (!w_busy) begin
                r_to_cnt <= '0;
            end else if (!mem_ready) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_strobe <= STRB_WORD;
            r_if_done    <= 1'b0;
            r_d_done     <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state      <= ST_BUSY_D;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= d_we;
                        r_mem_addr   <= d_addr;
                        r_mem_wdata  <= d_wdata;
                        r_mem_strobe <= d_strobe;
                    end else if (w_grant_if) begin
                        r_state      <= ST_BUSY_IF;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= if_addr;
                        r_mem_wdata  <= '0;
                        r_mem_strobe <= STRB_WORD;
                    end
                end
                ST_BUSY_IF, ST_BUSY_D: begin
                    if (w_complete) begin
                        r_state   <= ST_RESP;
                        r_mem_req <= 1'b0;
                        if (w_owner == OWN_IF) begin
                            r_if_rdata <= w_rsp_data;
                            r_if_done  <= 1'b1;
                        end else begin
                            r_d_rdata <= w_rsp_data;
                            r_d_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_strobe = r_mem_strobe;
    assign if_done    = r_if_done;
    assign d_done     = r_d_done;
    assign if_rdata   = r_if_rdata;
    assign d_rdata    = r_d_rdata;
    assign stall_if   = if_req && !r_if_done;
    assign stall_d    = d_req && !r_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change 1ns after posedge, outputs sampled on negedge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_strobe;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        stall_if;
    logic        stall_d;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_strobe;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        err_timeout;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_MAX  (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_strobe   (d_strobe),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .stall_if   (stall_if),
        .stall_d    (stall_d),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_strobe (mem_strobe),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .err_timeout(err_timeout)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] d_seq;
        logic       exp_d;
        logic       exp_if;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_strobe = 2'b10; mem_ready = 1'b0; mem_rdata = '0;
        next_cyc;
        next_cyc;
        @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_strobe", {30'b0, mem_strobe}, 32'd2);
        chk("rst_if_done", {31'b0, if_done}, 32'd0);
        chk("rst_d_done", {31'b0, d_done}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
`ifdef MEM_ARB_TIMEOUT_EN
        chk("rst_err_timeout", {31'b0, err_timeout}, 32'd0);
`endif
        next_cyc;
        rst = 1'b0;

        // Single fetch, zero wait states
        next_cyc;
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("f_c0_stall_if", {31'b0, stall_if}, 32'd1);
        chk("f_c0_mem_req", {31'b0, mem_req}, 32'd0);
        next_cyc;
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("f_c1_mem_req", {31'b0, mem_req}, 32'd1);
        chk("f_c1_mem_addr", mem_addr, 32'h100);
        chk("f_c1_mem_we", {31'b0, mem_we}, 32'd0);
        chk("f_c1_mem_strobe", {30'b0, mem_strobe}, 32'd2);
        chk("f_c1_stall_if", {31'b0, stall_if}, 32'd1);
        next_cyc;
        mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("f_c2_if_done", {31'b0, if_done}, 32'd1);
        chk("f_c2_if_rdata", if_rdata, 32'h0050_0093);
        chk("f_c2_stall_if", {31'b0, stall_if}, 32'd0);
        chk("f_c2_mem_req", {31'b0, mem_req}, 32'd0);
        next_cyc;
        if_req = 1'b0;
        @(negedge clk);
        chk("f_c3_if_done", {31'b0, if_done}, 32'd0);

        // Half-word store, mem_ready in cycle 4
        next_cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_strobe = 2'b01;
        @(negedge clk);
        chk("s_c0_stall_d", {31'b0, stall_d}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            next_cyc;
            if (c == 4) mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("s_c%0d_mem_req", c), {31'b0, mem_req}, 32'd1);
            chk($sformatf("s_c%0d_mem_we", c), {31'b0, mem_we}, 32'd1);
            chk($sformatf("s_c%0d_mem_addr", c), mem_addr, 32'h2004);
            chk($sformatf("s_c%0d_mem_wdata", c), mem_wdata, 32'hDEAD_BEEF);
            chk($sformatf("s_c%0d_mem_strobe", c), {30'b0, mem_strobe}, 32'd1);
            chk($sformatf("s_c%0d_d_done", c), {31'b0, d_done}, 32'd0);
        end
        next_cyc;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("s_c5_d_done", {31'b0, d_done}, 32'd1);
        chk("s_c5_if_done", {31'b0, if_done}, 32'd0);
        chk("s_c5_mem_req", {31'b0, mem_req}, 32'd0);
        next_cyc;
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("s_c6_d_done", {31'b0, d_done}, 32'd0);

        // Load whose address changes mid-transaction
        next_cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_strobe = 2'b10;
        next_cyc;
        d_addr = 32'h80;
        @(negedge clk);
        chk("chg_c1_mem_addr", mem_addr, 32'h40);
        next_cyc;
        mem_ready = 1'b1; mem_rdata = 32'h0000_1234;
        @(negedge clk);
        chk("chg_c2_mem_addr", mem_addr, 32'h40);
        next_cyc;
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        chk("chg_c3_d_done", {31'b0, d_done}, 32'd1);
        chk("chg_c3_d_rdata", d_rdata, 32'h0000_1234);
        next_cyc;
        d_req = 1'b0;

        // Contention: both held, zero wait -> D,D,D,D,IF,D with a done every third cycle
        next_cyc;
        if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300;
        mem_ready = 1'b1; mem_rdata = 32'h0000_00A5;
        d_seq = 6'b101111;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) next_cyc;
            @(negedge clk);
            exp_d  = ((k % 3) == 2) &&  d_seq[k / 3];
            exp_if = ((k % 3) == 2) && !d_seq[k / 3];
            chk($sformatf("cont_k%0d_d_done", k), {31'b0, d_done}, {31'b0, exp_d});
            chk($sformatf("cont_k%0d_if_done", k), {31'b0, if_done}, {31'b0, exp_if});
        end
        next_cyc;
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;

        // Reset during BUSY_D
        next_cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1111_2222; d_strobe = 2'b00;
        next_cyc;
        rst = 1'b1;
        @(negedge clk);
        chk("rm_c1_mem_req", {31'b0, mem_req}, 32'd1);
        next_cyc;
        rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("rm_c2_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rm_c2_mem_addr", mem_addr, 32'd0);
        chk("rm_c2_mem_wdata", mem_wdata, 32'd0);
        chk("rm_c2_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rm_c2_mem_strobe", {30'b0, mem_strobe}, 32'd2);
        chk("rm_c2_d_done", {31'b0, d_done}, 32'd0);
        chk("rm_c2_d_rdata", d_rdata, 32'd0);
        next_cyc;
        @(negedge clk);
        chk("rm_c3_d_done", {31'b0, d_done}, 32'd0);
        chk("rm_c3_mem_req", {31'b0, mem_req}, 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: memory never answers
        next_cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_strobe = 2'b10; mem_rdata = 32'hCAFE_F00D;
        for (int c = 1; c <= 8; c++) begin
            next_cyc;
            @(negedge clk);
            chk($sformatf("to_c%0d_mem_req", c), {31'b0, mem_req}, 32'd1);
            chk($sformatf("to_c%0d_err", c), {31'b0, err_timeout}, 32'd0);
        end
        next_cyc;
        @(negedge clk);
        chk("to_c9_mem_req", {31'b0, mem_req}, 32'd0);
        chk("to_c9_d_done", {31'b0, d_done}, 32'd1);
        chk("to_c9_d_rdata", d_rdata, 32'd0);
        chk("to_c9_err", {31'b0, err_timeout}, 32'd1);
        next_cyc;
        d_req = 1'b0;
        @(negedge clk);
        chk("to_c10_d_done", {31'b0, d_done}, 32'd0);
        next_cyc;
        @(negedge clk);
        chk("to_c11_err_sticky", {31'b0, err_timeout}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and its load/store (MEM-stage) port.
- Sits between the core and the memory. It serialises requests, holds the captured address/data for the duration of each transaction, and returns per-requester done pulses and stall levels that the pipeline uses to freeze PC and the pipeline registers.
- Data requests take priority; an anti-starvation counter bounds the fetch wait.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive data grants while a fetch is pending (range 1..15)
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; level, held until if_done
- if_addr  in  ADDR_W  fetch address (PC)
- if_done  out  1  one-cycle pulse, fetch complete
- if_rdata  out  DATA_W  fetched instruction; valid while if_done=1
- d_req  in  1  load/store request; level, held until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_strobe  in  2  00 byte, 01 half, 10 word (same encoding as the core's write strobe)
- d_done  out  1  one-cycle pulse, data access complete
- d_rdata  out  DATA_W  raw load data; valid while d_done=1
- stall_if  out  1  if_req & ~if_done
- stall_d  out  1  d_req & ~d_done
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_strobe  out  2  memory size
- mem_ready  in  1  one-cycle completion; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: all state updates on the rising edge of clk; reset is synchronous, active-high.
- Reset values: state=IDLE; mem_req, mem_we, if_done, d_done = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; mem_strobe=10; starve_cnt=0.
- State machine states: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE arbitration:
  - d_req=1 and (if_req=0 or starve_cnt<STARVE_MAX): grant data, go to BUSY_D, starve_cnt += if_req (saturating).
  - Otherwise if if_req=1: grant fetch, go to BUSY_IF, starve_cnt=0.
  - With no request, starve_cnt=0.
- Capture on grant: requester fields are registered onto mem_* at the grant edge. Fetch grants drive mem_we=0 and mem_strobe=10.
- BUSY_x:
  - mem_req=1 and all mem_* stable until mem_ready.
  - On mem_ready: capture mem_rdata into the granted requester's rdata, drop mem_req, go to RESP.
  - No timeout unless the optional feature is enabled.
- RESP: the granted requester's done pulses for exactly one cycle (stores pulse too; d_rdata is don't-care for them). No arbitration in this cycle, so the requester can drop or change its request. Go to IDLE.
- Latency: request seen in IDLE at cycle 0; mem_req from cycle 1; if mem_ready arrives in cycle 1+W, done is asserted in cycle 2+W. Minimum latency is 3 cycles; throughput is one access per 3+W cycles.
- Simultaneous if_req and d_req in IDLE: data wins unless starve_cnt==STARVE_MAX.
- Requests arriving during BUSY/RESP: ignored until IDLE. Requester inputs changing mid-transaction have no effect, because fields were captured at grant.
- mem_ready outside BUSY: ignored.
- Reset mid-transaction: mem_req=0 on the next cycle, the outstanding transaction is abandoned, and no done pulse is produced. The memory must discard it.
- Addresses, alignment and strobe are passed through unchecked; sign extension and byte lanes are handled by the existing load unit.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - Adds output err_timeout (1 bit, reset 0).
  - A counter runs in BUSY_x. At TIMEOUT_CYC cycles without mem_ready: drop mem_req, go to RESP, pulse done with rdata=0, and set err_timeout sticky until rst.
- When undefined: no counter, no port; BUSY_x waits forever.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, BUSY_IF, BUSY_D, RESP)
  - strobe constants (STRB_BYTE=00, STRB_HALF=01, STRB_WORD=10)
  - grant-owner encoding
- One natural sub-module: mem_arb_starve_ctr (saturating counter with clear, compare to STARVE_MAX).
- The FSM and the datapath registers stay in the top module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ready in cycle 1 with rdata=0x00500093 -> mem_req in cycle 1 with mem_addr=0x100 and mem_we=0; if_done=1 with if_rdata=0x00500093 in cycle 2; stall_if=1 in cycles 0-1.
- Store with wait states: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_strobe=01, mem_ready in cycle 4 -> mem_* held constant in cycles 1-4; d_done pulse in cycle 5; no if_done.
- Contention and starvation: if_req and d_req held high, STARVE_MAX=4, zero wait -> grant order D,D,D,D,IF,D,...; exactly one done per 3 cycles.
- Input change mid-transaction: change d_addr from 0x40 to 0x80 during BUSY_D -> mem_addr stays 0x40.
- Reset mid-transaction: rst=1 in a BUSY_D cycle -> mem_req=0 next cycle; no d_done; all outputs at reset values.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYC=8 and mem_ready never asserted -> mem_req drops after 8 BUSY cycles; d_done pulses with d_rdata=0; err_timeout=1 and stays set.
